// File: rtl/charlieplex_scanner.sv
// ---------------------------------------------------------------------------
// charlieplex_scanner
//
// Time-multiplexed driver for a charlieplexed LED array. PINCOUNT pins address
// PINCOUNT*(PINCOUNT-1) LEDs; one LED is lit per slot. Every slot starts with
// a tristate blanking gap so the previous LED's pins are released before the
// next pair is driven (no ghosting).
//
// A 1-bit-per-LED frame is double buffered: the bus side writes the back
// buffer, and a commit request copies back -> front at the next frame
// boundary so a frame is never displayed half-updated.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   enable         : scan enable; 0 parks the scan with all pins tristate
//   wr_en          : write one bit into the back buffer
//   wr_addr        : LED index to write (out-of-range indices are ignored)
//   wr_data        : LED on(1)/off(0)
//   commit         : one-cycle request to copy back -> front at next boundary
//   commit_pending : a commit has been requested but not applied yet
//   frame_start    : one-cycle pulse on the first blank cycle of index 0
//   out_en         : per-pin output enable (0 = tristate)
//   out_value      : per-pin level when enabled
// ---------------------------------------------------------------------------
module charlieplex_scanner #(
    parameter int PINCOUNT     = 4,
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    localparam int LEDCOUNT    = PINCOUNT * (PINCOUNT - 1),
    localparam int INDEXBITS   = $clog2(LEDCOUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [INDEXBITS-1:0] wr_addr,
    input  logic                 wr_data,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic                 frame_start,
    output logic [PINCOUNT-1:0]  out_en,
    output logic [PINCOUNT-1:0]  out_value
);

    localparam int PINW   = $clog2(PINCOUNT);
    localparam int CNTMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNTW   = $clog2(CNTMAX + 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [INDEXBITS-1:0]   index_q, index_d;
    logic [PINW-1:0]        vcc_q, vcc_d;
    logic [PINW-1:0]        r_q, r_d;
    logic [LEDCOUNT-1:0]    front_q, front_d;
    logic [LEDCOUNT-1:0]    back_q, back_d;
    logic                   pending_q, pending_d;
    logic                   frame_start_q, frame_start_d;
    logic [PINCOUNT-1:0]    out_en_q, out_en_d;
    logic [PINCOUNT-1:0]    out_value_q, out_value_d;

    logic [PINW-1:0]        gnd;
    logic [PINCOUNT-1:0]    slot_en;
    logic [PINCOUNT-1:0]    slot_val;
    logic                   wr_addr_ok;
    logic                   boundary;

    // The ground pin skips over the vcc pin, so vcc and gnd can never collide.
    assign gnd = (r_q < vcc_q) ? r_q : r_q + PINW'(1);

    // Per-pin decode of the current LED's anode/cathode pair.
    for (genvar gi = 0; gi < PINCOUNT; gi++) begin : g_pin
        assign slot_en[gi]  = (vcc_q == PINW'(gi)) || (gnd == PINW'(gi));
        assign slot_val[gi] = (vcc_q == PINW'(gi));
    end

    assign wr_addr_ok = ({1'b0, wr_addr} < (INDEXBITS + 1)'(LEDCOUNT));

    always_comb begin
        back_d = back_q;
        if (wr_en && wr_addr_ok) begin
            back_d[wr_addr] = wr_data;
        end

        state_d       = state_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        vcc_d         = vcc_q;
        r_d           = r_q;
        front_d       = front_q;
        pending_d     = pending_q | commit;
        frame_start_d = 1'b0;
        out_en_d      = '0;
        out_value_d   = '0;
        boundary      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            index_d = '0;
            vcc_d   = '0;
            r_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Index is already 0 in IDLE; leaving it starts a frame.
                    state_d       = BLANK;
                    cnt_d         = '0;
                    frame_start_d = 1'b1;
                    boundary      = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == CNTW'(BLANK_CYCLES - 1)) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        if (front_q[index_q]) begin
                            out_en_d    = slot_en;
                            out_value_d = slot_val;
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == CNTW'(DWELL_CYCLES - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (index_q == INDEXBITS'(LEDCOUNT - 1)) begin
                            index_d       = '0;
                            vcc_d         = '0;
                            r_d           = '0;
                            frame_start_d = 1'b1;
                            boundary      = 1'b1;
                        end else begin
                            index_d = index_q + INDEXBITS'(1);
                            // r counts 0..PINCOUNT-2 within each vcc group.
                            if (r_q == PINW'(PINCOUNT - 2)) begin
                                r_d   = '0;
                                vcc_d = vcc_q + PINW'(1);
                            end else begin
                                r_d = r_q + PINW'(1);
                            end
                        end
                    end else begin
                        cnt_d       = cnt_q + CNTW'(1);
                        out_en_d    = out_en_q;
                        out_value_d = out_value_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Copy (not swap) so the back buffer keeps its contents; a write in
        // the boundary cycle is part of the copied image.
        if (boundary && (pending_q || commit)) begin
            front_d   = back_d;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            index_q       <= '0;
            vcc_q         <= '0;
            r_q           <= '0;
            front_q       <= '0;
            back_q        <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            out_en_q      <= '0;
            out_value_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            index_q       <= index_d;
            vcc_q         <= vcc_d;
            r_q           <= r_d;
            front_q       <= front_d;
            back_q        <= back_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            out_en_q      <= out_en_d;
            out_value_q   <= out_value_d;
        end
    end

    assign commit_pending = pending_q;
    assign frame_start    = frame_start_q;
    assign out_en         = out_en_q;
    assign out_value      = out_value_q;

endmodule
